// File: rtl/pps_sched_pkg.sv
// Shared types and constants for the 1PPS channel scheduler and its helpers.
package pps_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SLOT  = 2'd2,
    GUARD = 2'd3
  } state_e;

  localparam int          CH_W    = 4;
  localparam logic [3:0]  CH_IDLE = 4'hF;

  // Width of the shared slot/guard down-counter; at least one bit.
  function automatic int cnt_width(input int slot_cycles, input int guard_cycles);
    int m;
    m = (slot_cycles > guard_cycles) ? slot_cycles : guard_cycles;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// Three-flop synchroniser for the raw 1PPS input with a one-cycle rising-edge pulse.
module pps_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic pps_i,
  output logic pps_rise_o
);

  logic s1_q, s2_q, s3_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= pps_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign pps_rise_o = s2_q & ~s3_q;

endmodule

// File: rtl/pps_channel_scheduler.sv
// Once-per-second channel sequencer: walks the channels after each 1PPS edge,
// granting each eligible one a fixed-length slot followed by a guard gap.
module pps_channel_scheduler
  import pps_sched_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int SLOT_CYCLES  = 20000,
  parameter int GUARD_CYCLES = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pps,
  input  logic              transmit_enble,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic              slot_done,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   channel_number,
  output logic              busy,
  output logic              frame_done,
  output logic              missed_pps
);

  localparam int              CNT_W        = cnt_width(SLOT_CYCLES, GUARD_CYCLES);
  localparam int              GUARD_LOAD_I = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] SLOT_LOAD   = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD  = CNT_W'(GUARD_LOAD_I);
  localparam logic [CH_W-1:0]  LAST_IDX    = CH_W'(NUM_CH - 1);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]     chn_q, chn_d;
  logic                frame_done_q, frame_done_d;
  logic                missed_q, missed_d;

  logic                pps_rise;
  logic                eligible;
  logic [NUM_CH-1:0]   idx_onehot;
  logic                is_last, slot_end, guard_end;

  pps_edge_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .pps_i      (pps),
    .pps_rise_o (pps_rise)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    eligible   = 1'b0;
    idx_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_q == CH_W'(i)) begin
        eligible      = ch_mask[i] & ch_ready[i];
        idx_onehot[i] = 1'b1;
      end
    end
  end

  assign is_last   = (idx_q == LAST_IDX);
  assign slot_end  = (cnt_q == '0) || slot_done;
  assign guard_end = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      grant_q      <= '0;
      chn_q        <= CH_IDLE;
      frame_done_q <= 1'b0;
      missed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      chn_q        <= chn_d;
      frame_done_q <= frame_done_d;
      missed_q     <= missed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!transmit_enble) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (pps_rise) begin
          state_d = SCAN;
          idx_d   = '0;
        end
        SCAN: if (eligible) begin
          state_d = SLOT;
          cnt_d   = SLOT_LOAD;
        end else if (is_last) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
        SLOT: if (slot_end) begin
          if (GUARD_CYCLES > 0) begin
            state_d = GUARD;
            cnt_d   = GUARD_LOAD;
          end else if (is_last) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            state_d = SCAN;
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        GUARD: if (guard_end) begin
          if (is_last) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            state_d = SCAN;
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Registered outputs change on the same edge as the state transition they belong to.
  always_comb begin
    grant_d      = grant_q;
    chn_d        = chn_q;
    frame_done_d = 1'b0;
    missed_d     = pps_rise && (state_q != IDLE);
    if (!transmit_enble) begin
      grant_d = '0;
      chn_d   = CH_IDLE;
    end else begin
      case (state_q)
        SCAN: if (eligible) begin
          grant_d = idx_onehot;
          chn_d   = idx_q;
        end else if (is_last) begin
          frame_done_d = 1'b1;
        end
        SLOT: if (slot_end) begin
          grant_d      = '0;
          chn_d        = CH_IDLE;
          frame_done_d = (GUARD_CYCLES == 0) && is_last;
        end
        GUARD: frame_done_d = guard_end && is_last;
        default: ;
      endcase
    end
  end

  assign grant          = grant_q;
  assign channel_number = chn_q;
  assign busy           = (state_q != IDLE);
  assign frame_done     = frame_done_q;
  assign missed_pps     = missed_q;

endmodule
